// File: rtl/unified_mem_arbiter.sv
// Shares one single-port unified RAM between instruction fetch and load/store.
// Data accesses win ties, but a bounded data streak lets a waiting fetch through.
module unified_mem_arbiter #(
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_rw,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_stall,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [1:0]  ram_size,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        grant_owner
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [2:0] LAST_CNT   = 3'(MEM_LATENCY - 1);
  localparam logic [2:0] STREAK_MAX = 3'(MAX_DATA_STREAK);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  streak_q, streak_d;
  logic        ram_en_q, ram_en_d;
  logic        ram_rw_q, ram_rw_d;
  logic [1:0]  ram_size_q, ram_size_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        owner_q, owner_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_elig, mem_elig, grant_data;

  // A requester in its ack cycle is ignored so a dropping req is not re-granted.
  assign if_elig    = if_req & ~if_ack_q;
  assign mem_elig   = mem_req & ~mem_ack_q;
  assign grant_data = mem_elig & (~if_elig | (streak_q != STREAK_MAX));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    ram_en_d    = ram_en_q;
    ram_rw_d    = ram_rw_q;
    ram_size_d  = ram_size_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    owner_d     = owner_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_elig || mem_elig) begin
          state_d  = ACCESS;
          cnt_d    = 3'd0;
          ram_en_d = 1'b1;
          owner_d  = grant_data;
          if (grant_data) begin
            ram_rw_d    = mem_rw;
            ram_size_d  = mem_size;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
            if (!if_req)
              streak_d = 3'd0;
            else if (streak_q != STREAK_MAX)
              streak_d = streak_q + 3'd1;
          end else begin
            ram_rw_d   = 1'b0;
            ram_size_d = 2'b10;
            ram_addr_d = if_addr;
            streak_d   = 3'd0;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) begin
          state_d  = IDLE;
          ram_en_d = 1'b0;
          if (owner_q) begin
            mem_ack_d = 1'b1;
            if (!ram_rw_q)
              mem_rdata_d = ram_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = ram_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      streak_q    <= 3'd0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_size_q  <= 2'b00;
      ram_addr_q  <= 32'h0;
      ram_wdata_q <= 32'h0;
      owner_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_size_q  <= ram_size_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      owner_q     <= owner_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_rw      = ram_rw_q;
  assign ram_size    = ram_size_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign grant_owner = owner_q;
  assign if_ack      = if_ack_q;
  assign mem_ack     = mem_ack_q;
  assign if_rdata    = if_rdata_q;
  assign mem_rdata   = mem_rdata_q;
  assign if_stall    = if_req & ~if_ack_q;
  assign mem_stall   = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios on a latency-1 and a latency-3
// instance, then random traffic checked against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int MAXS = 2;

  logic        clk = 1'b0;
  logic        clr_a, clr_b;
  logic        if_req, mem_req, mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] ram_word [256];

  logic [31:0] a_if_rdata, a_mem_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic        a_if_ack, a_if_stall, a_mem_ack, a_mem_stall, a_ram_en, a_ram_rw, a_grant_owner;
  logic [1:0]  a_ram_size;
  logic [31:0] b_if_rdata, b_mem_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic        b_if_ack, b_if_stall, b_mem_ack, b_mem_stall, b_ram_en, b_ram_rw, b_grant_owner;
  logic [1:0]  b_ram_size;

  always #5 clk = ~clk;

  assign a_ram_rdata = a_ram_en ? ram_word[a_ram_addr[7:0]] : 32'h0;
  assign b_ram_rdata = b_ram_en ? ram_word[b_ram_addr[7:0]] : 32'h0;

  unified_mem_arbiter #(.MEM_LATENCY(1), .MAX_DATA_STREAK(MAXS)) u_l1 (
    .CLK(clk), .CLR(clr_a),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .if_stall(a_if_stall),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
    .mem_stall(a_mem_stall),
    .ram_en(a_ram_en), .ram_rw(a_ram_rw), .ram_size(a_ram_size), .ram_addr(a_ram_addr),
    .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata), .grant_owner(a_grant_owner)
  );

  unified_mem_arbiter #(.MEM_LATENCY(3), .MAX_DATA_STREAK(MAXS)) u_l3 (
    .CLK(clk), .CLR(clr_b),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .if_stall(b_if_stall),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
    .mem_stall(b_mem_stall),
    .ram_en(b_ram_en), .ram_rw(b_ram_rw), .ram_size(b_ram_size), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata), .grant_owner(b_grant_owner)
  );

  // Selected-instance view used by the random phase
  logic        use_b = 1'b0;
  logic        o_ram_en, o_ram_rw, o_owner, o_if_ack, o_mem_ack, o_if_stall, o_mem_stall;
  logic [1:0]  o_ram_size;
  logic [31:0] o_ram_addr, o_ram_wdata, o_if_rdata, o_mem_rdata;
  assign o_ram_en    = use_b ? b_ram_en      : a_ram_en;
  assign o_ram_rw    = use_b ? b_ram_rw      : a_ram_rw;
  assign o_owner     = use_b ? b_grant_owner : a_grant_owner;
  assign o_if_ack    = use_b ? b_if_ack      : a_if_ack;
  assign o_mem_ack   = use_b ? b_mem_ack     : a_mem_ack;
  assign o_if_stall  = use_b ? b_if_stall    : a_if_stall;
  assign o_mem_stall = use_b ? b_mem_stall   : a_mem_stall;
  assign o_ram_size  = use_b ? b_ram_size    : a_ram_size;
  assign o_ram_addr  = use_b ? b_ram_addr    : a_ram_addr;
  assign o_ram_wdata = use_b ? b_ram_wdata   : a_ram_wdata;
  assign o_if_rdata  = use_b ? b_if_rdata    : a_if_rdata;
  assign o_mem_rdata = use_b ? b_mem_rdata   : a_mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a countdown of access cycles left plus the visible registers
  int          m_left, m_streak;
  bit          m_en, m_own, m_rw, m_iack, m_mack;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_ird, m_mrd;

  task automatic model_reset();
    m_left = 0; m_streak = 0;
    m_en = 0; m_own = 0; m_rw = 0; m_iack = 0; m_mack = 0;
    m_size = 2'b00; m_addr = 0; m_wdata = 0; m_ird = 0; m_mrd = 0;
  endtask

  task automatic model_step(input int lat, input bit clr);
    bit e_i, e_m;
    if (clr) begin
      model_reset();
      return;
    end
    e_i = if_req && !m_iack;
    e_m = mem_req && !m_mack;
    m_iack = 0;
    m_mack = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_en = 0;
        if (m_own) begin
          m_mack = 1;
          if (!m_rw) m_mrd = ram_word[m_addr[7:0]];
        end else begin
          m_iack = 1;
          m_ird = ram_word[m_addr[7:0]];
        end
      end
    end else if (e_m && (!e_i || m_streak < MAXS)) begin
      m_left = lat; m_en = 1; m_own = 1;
      m_rw = mem_rw; m_size = mem_size; m_addr = mem_addr; m_wdata = mem_wdata;
      m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
    end else if (e_i) begin
      m_left = lat; m_en = 1; m_own = 0;
      m_rw = 0; m_size = 2'b10; m_addr = if_addr;
      m_streak = 0;
    end
  endtask

  task automatic run_random(input bit sel, input int lat, input int n);
    bit c;
    use_b = sel;
    clr_a = 1; clr_b = 1;
    if_req = 0; mem_req = 0; mem_rw = 0; mem_size = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0;
    tick(); tick();
    model_reset();
    c = 0;
    if (sel) clr_b = 0; else clr_a = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      model_step(lat, c);
      chk("rnd ram_en",    o_ram_en,    m_en);
      chk("rnd owner",     o_owner,     m_own);
      chk("rnd if_ack",    o_if_ack,    m_iack);
      chk("rnd mem_ack",   o_mem_ack,   m_mack);
      chk("rnd if_rdata",  o_if_rdata,  m_ird);
      chk("rnd mem_rdata", o_mem_rdata, m_mrd);
      chk("rnd ram_addr",  o_ram_addr,  m_addr);
      chk("rnd ram_rw",    o_ram_rw,    m_rw);
      chk("rnd ram_size",  o_ram_size,  m_size);
      chk("rnd ram_wdata", o_ram_wdata, m_wdata);
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
      end else if (m_iack) begin
        if ($urandom_range(0, 1) == 0) if_req = 0; else if_addr = $urandom;
      end
      if (!mem_req || m_mack) begin
        if (mem_req && $urandom_range(0, 1) == 0) mem_req = 0;
        else if (mem_req || $urandom_range(0, 2) == 0) begin
          mem_req = 1; mem_rw = 1'($urandom); mem_size = 2'($urandom);
          mem_addr = $urandom; mem_wdata = $urandom;
        end
      end
      c = ($urandom_range(0, 79) == 0);
      if (sel) clr_b = c; else clr_a = c;
      #1;
      chk("rnd if_stall",  o_if_stall,  if_req && !m_iack);
      chk("rnd mem_stall", o_mem_stall, mem_req && !m_mack);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram_word[i] = $urandom;
    ram_word[8'h00] = 32'h1122_3344;
    ram_word[8'h08] = 32'hE3A0_1005;
    ram_word[8'h10] = 32'hDEAD_BEEF;
    ram_word[8'h14] = 32'hCAFE_F00D;
    ram_word[8'h20] = 32'h0000_0055;

    // Reset with both requesters active
    clr_a = 1; clr_b = 1;
    if_req = 1; if_addr = 32'h0;
    mem_req = 1; mem_rw = 0; mem_size = 2'b10; mem_addr = 32'h20; mem_wdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst ram_en",    a_ram_en,      0);
      chk("rst owner",     a_grant_owner, 0);
      chk("rst if_ack",    a_if_ack,      0);
      chk("rst mem_ack",   a_mem_ack,     0);
      chk("rst ram_addr",  a_ram_addr,    0);
      chk("rst ram_wdata", a_ram_wdata,   0);
      chk("rst ram_size",  a_ram_size,    0);
      chk("rst if_rdata",  a_if_rdata,    0);
      chk("rst mem_rdata", a_mem_rdata,   0);
      chk("rst if_stall",  a_if_stall,    1);
    end
    clr_a = 0;

    // Simultaneous fetch 0x0 and load 0x20: data first, then fetch
    tick();
    chk("sim c1 ram_en",   a_ram_en,      1);
    chk("sim c1 owner",    a_grant_owner, 1);
    chk("sim c1 ram_addr", a_ram_addr,    32'h20);
    chk("sim c1 if_stall", a_if_stall,    1);
    tick();
    chk("sim c2 mem_ack",   a_mem_ack,   1);
    chk("sim c2 mem_rdata", a_mem_rdata, 32'h55);
    chk("sim c2 ram_en",    a_ram_en,    0);
    chk("sim c2 if_stall",  a_if_stall,  1);
    mem_req = 0;
    tick();
    chk("sim c3 ram_en",   a_ram_en,      1);
    chk("sim c3 owner",    a_grant_owner, 0);
    chk("sim c3 ram_size", a_ram_size,    2'b10);
    chk("sim c3 if_stall", a_if_stall,    1);
    tick();
    chk("sim c4 if_ack",   a_if_ack,   1);
    chk("sim c4 if_rdata", a_if_rdata, 32'h1122_3344);
    chk("sim c4 if_stall", a_if_stall, 0);
    if_req = 0;
    tick();

    // Single fetch at latency 1
    if_req = 1; if_addr = 32'h8;
    tick();
    chk("fetch c1 ram_en",   a_ram_en,   1);
    chk("fetch c1 ram_addr", a_ram_addr, 32'h8);
    chk("fetch c1 ram_rw",   a_ram_rw,   0);
    chk("fetch c1 if_ack",   a_if_ack,   0);
    tick();
    chk("fetch c2 if_ack",   a_if_ack,   1);
    chk("fetch c2 if_rdata", a_if_rdata, 32'hE3A0_1005);
    chk("fetch c2 if_stall", a_if_stall, 0);
    if_req = 0;
    tick();
    chk("fetch c3 if_ack",   a_if_ack,   0);
    chk("fetch c3 ram_en",   a_ram_en,   0);

    // Byte store
    mem_req = 1; mem_rw = 1; mem_size = 2'b00; mem_addr = 32'h40; mem_wdata = 32'hAB;
    tick();
    chk("st c1 ram_en",    a_ram_en,    1);
    chk("st c1 ram_rw",    a_ram_rw,    1);
    chk("st c1 ram_size",  a_ram_size,  2'b00);
    chk("st c1 ram_addr",  a_ram_addr,  32'h40);
    chk("st c1 ram_wdata", a_ram_wdata, 32'hAB);
    tick();
    chk("st c2 mem_ack",   a_mem_ack,   1);
    chk("st c2 mem_rdata", a_mem_rdata, 32'h55);
    chk("st c2 ram_en",    a_ram_en,    0);
    mem_req = 0; mem_rw = 0; mem_size = 2'b10;
    tick();

    // Streak limit: both requesters re-raise together after every ack
    for (int r = 0; r < 6; r++) begin
      if_req = 1; mem_req = 1; if_addr = 32'h4 * r; mem_addr = 32'h80 + r;
      tick();
      chk("streak ram_en", a_ram_en, 1);
      chk("streak owner",  a_grant_owner, (r % 3 == 2) ? 0 : 1);
      tick();
      chk("streak ack", (r % 3 == 2) ? a_if_ack : a_mem_ack, 1);
      if_req = 0; mem_req = 0;
      tick();
    end

    // Reset during the second access cycle at latency 3
    clr_a = 1; clr_b = 0;
    if_req = 1; if_addr = 32'h10;
    tick();
    chk("abort c1 ram_en",   b_ram_en,   1);
    chk("abort c1 ram_addr", b_ram_addr, 32'h10);
    tick();
    chk("abort c2 ram_en",   b_ram_en,   1);
    clr_b = 1;
    tick();
    chk("abort c3 ram_en",   b_ram_en,      0);
    chk("abort c3 if_ack",   b_if_ack,      0);
    chk("abort c3 owner",    b_grant_owner, 0);
    chk("abort c3 ram_addr", b_ram_addr,    0);
    clr_b = 0; if_req = 0;
    tick();
    chk("abort c4 if_ack",   b_if_ack, 0);
    chk("abort c4 ram_en",   b_ram_en, 0);
    if_req = 1; if_addr = 32'h14;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rereq ram_en", b_ram_en, (k <= 3) ? 1 : 0);
      chk("rereq if_ack", b_if_ack, (k == 4) ? 1 : 0);
    end
    chk("rereq if_rdata", b_if_rdata, 32'hCAFE_F00D);
    if_req = 0;
    tick();

    run_random(1'b1, 3, 600);
    run_random(1'b0, 1, 600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
